// File: rtl/trace_pkg.sv
// Shared types and constants for the pipeline trace buffer.
// Latency: n/a (types only).
// Backpressure: n/a.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int TS_W = 32;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage, one write port and one read port on one clock.
// Latency: read data appears one cycle after the read address is presented.
// Backpressure: none; read port re-reads every cycle, so a held address holds the data.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 144
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write on request, registered read every cycle; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_trace_buf.sv
// Trigger-based pipeline trace buffer: circular capture, trigger + POST_N samples, oldest-first readout.
// Latency: ow_rd_valid rises one cycle after DONE is entered; one entry per cycle under sustained ready.
// Backpressure: valid/ready readout, entry held stable while not ready. Timestamps enabled by TRACE_TIMESTAMP_EN.
module pipe_trace_buf
  import trace_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 16,
  parameter int POST_N   = 4
) (
  input  logic                          iw_clk,
  input  logic                          iw_rst_n,
  input  logic                          iw_arm,
  input  logic                          iw_cap_en,
  input  logic [CHANNELS*WIDTH-1:0]     iw_ch_data,
  input  logic [$clog2(CHANNELS)-1:0]   iw_trig_ch,
  input  logic [WIDTH-1:0]              iw_trig_val,
  output logic [1:0]                    ow_state,
  output logic [$clog2(DEPTH):0]        ow_count,
  output logic                          ow_rd_valid,
  input  logic                          iw_rd_ready,
  output logic [CHANNELS*WIDTH-1:0]     ow_rd_data,
  output logic [31:0]                   ow_rd_ts
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TW   = $clog2(CHANNELS);
  localparam int DW_D = CHANNELS * WIDTH;
`ifdef TRACE_TIMESTAMP_EN
  localparam int DW   = DW_D + TS_W;
`else
  localparam int DW   = DW_D;
`endif
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_N);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] post_cnt, post_nxt;
  logic          rd_valid, rd_valid_nxt;
  logic          wr_en;
  logic          trig_hit;
  logic          pop;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] wr_word;
  logic [DW-1:0] rd_word;

  // Compare the selected channel; an out-of-range channel index matches nothing.
  always_comb begin
    trig_hit = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (iw_trig_ch == TW'(c) && iw_ch_data[c*WIDTH +: WIDTH] == iw_trig_val) trig_hit = 1'b1;
    end
  end

  assign pop = rd_valid & iw_rd_ready;

  // Oldest entry is always wr_ptr - count since the buffer is frozen during readout;
  // on a pop fetch the following entry so the next one is ready without a bubble.
  assign rd_base = wr_ptr - count[AW-1:0];
  assign rd_addr = pop ? rd_base + 1'b1 : rd_base;

  // Next-state and datapath control for capture, trigger, post-capture and drain.
  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    count_nxt    = count;
    post_nxt     = post_cnt;
    rd_valid_nxt = 1'b0;
    wr_en        = 1'b0;
    if (iw_arm) begin
      state_nxt  = ST_ARMED;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
      post_nxt   = '0;
    end else begin
      case (state)
        ST_ARMED, ST_POST: begin
          if (iw_cap_en) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (count != FULL) count_nxt = count + 1'b1;
            if (state == ST_ARMED) begin
              if (trig_hit) begin
                if (POST_N == 0) begin
                  state_nxt = ST_DONE;
                end else begin
                  state_nxt = ST_POST;
                  post_nxt  = POST_INIT;
                end
              end
            end else begin
              post_nxt = post_cnt - 1'b1;
              if (post_cnt == AW'(1)) state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (pop) count_nxt = count - 1'b1;
          rd_valid_nxt = (count_nxt != '0);
          if (count_nxt == '0) state_nxt = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      count    <= count_nxt;
      post_cnt <= post_nxt;
      rd_valid <= rd_valid_nxt;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) ts_cnt <= '0;
    else           ts_cnt <= ts_cnt + 1'b1;
  end

  assign wr_word  = {ts_cnt, iw_ch_data};
  assign ow_rd_ts = rd_valid ? rd_word[DW-1 -: TS_W] : '0;
`else
  assign wr_word  = iw_ch_data;
  assign ow_rd_ts = '0;
`endif

  trace_ram #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ram (
    .clk   (iw_clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // RAM output is not reset, so it is masked whenever no entry is being presented.
  assign ow_rd_data  = rd_valid ? rd_word[DW_D-1:0] : '0;
  assign ow_rd_valid = rd_valid;
  assign ow_count    = count;
  assign ow_state    = state;

endmodule

// File: tb/tb_pipe_trace_buf.sv
// Directed self-checking bench for pipe_trace_buf (default and POST_N=0 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_trace_buf;

  localparam int CH = 6;
  localparam int W  = 24;
  localparam int D  = 16;
  localparam int DW = CH * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm, cap_en, rd_ready;
  logic [DW-1:0] ch_data;
  logic [2:0]    trig_ch;
  logic [W-1:0]  trig_val;

  logic [1:0]    st0, st1;
  logic [4:0]    cnt0, cnt1;
  logic          vld0, vld1;
  logic [DW-1:0] dat0, dat1;
  logic [31:0]   ts0, ts1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_trace_buf #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .POST_N(4)) dut0 (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_arm(arm), .iw_cap_en(cap_en),
    .iw_ch_data(ch_data), .iw_trig_ch(trig_ch), .iw_trig_val(trig_val),
    .ow_state(st0), .ow_count(cnt0), .ow_rd_valid(vld0), .iw_rd_ready(rd_ready),
    .ow_rd_data(dat0), .ow_rd_ts(ts0)
  );

  pipe_trace_buf #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .POST_N(0)) dut1 (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_arm(arm), .iw_cap_en(cap_en),
    .iw_ch_data(ch_data), .iw_trig_ch(trig_ch), .iw_trig_val(trig_val),
    .ow_state(st1), .ow_count(cnt1), .ow_rd_valid(vld1), .iw_rd_ready(rd_ready),
    .ow_rd_data(dat1), .ow_rd_ts(ts1)
  );

  function automatic logic [DW-1:0] mk(input int v);
    logic [DW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) r[c*W +: W] = W'(v + (c << 20));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid0(input string tag);
    int n;
    n = 0;
    while (vld0 !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk(tag, 64'(vld0), 64'd1);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  pat;
    logic [31:0] prev_ts;
    int e, cyc;

    rst_n = 1'b0; arm = 1'b0; cap_en = 1'b0; rd_ready = 1'b0;
    ch_data = '0; trig_ch = '0; trig_val = '0;
    pat = 4'b1001;
    prev_ts = '0;
    tick(); tick();

    // reset state
    chk("rst_state", 64'(st0), 64'd0);
    chk("rst_count", 64'(cnt0), 64'd0);
    chk("rst_valid", 64'(vld0), 64'd0);
    chk("rst_data", dat0[63:0], 64'd0);
    chk("rst_ts", 64'(ts0), 64'd0);
    rst_n = 1'b1;
    tick();

    // basic capture: trigger 0x0A, four post samples
    trig_ch = 3'd0; trig_val = 24'h00000A;
    do_arm();
    chk("arm_state", 64'(st0), 64'd1);
    chk("arm_count", 64'(cnt0), 64'd0);
    for (int i = 1; i <= 20; i++) begin
      cap_en = 1'b1; ch_data = mk(i);
      tick();
      if (i == 14) begin
        chk("basic_done_state", 64'(st0), 64'd3);
        chk("basic_done_novalid", 64'(vld0), 64'd0);
      end
      if (i == 15) begin
        chk("basic_valid_lat", 64'(vld0), 64'd1);
        chk("basic_count", 64'(cnt0), 64'd14);
      end
    end
    cap_en = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      chk("basic_rd_valid", 64'(vld0), 64'd1);
      chk("basic_rd_ch0", 64'(dat0[W-1:0]), 64'(k));
      if (k == 1) chk("basic_rd_ch5", 64'(dat0[5*W +: W]), 64'(32'h500001));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    chk("basic_end_valid", 64'(vld0), 64'd0);
    chk("basic_end_state", 64'(st0), 64'd0);
    chk("basic_end_count", 64'(cnt0), 64'd0);

    // wrap with backpressure 1,0,0,1
    trig_val = 24'h000018;
    do_arm();
    for (int i = 1; i <= 28; i++) begin
      cap_en = 1'b1; ch_data = mk(i);
      tick();
    end
    cap_en = 1'b0;
    chk("wrap_state", 64'(st0), 64'd3);
    chk("wrap_count", 64'(cnt0), 64'd16);
    wait_valid0("wrap_valid");
    e = 13; cyc = 0;
    while (e <= 28 && cyc < 100) begin
      chk("wrap_rd_valid", 64'(vld0), 64'd1);
      chk("wrap_rd_ch0", 64'(dat0[W-1:0]), 64'(e));
      rd_ready = pat[cyc % 4];
      tick();
      if (rd_ready) e++;
      cyc++;
    end
    rd_ready = 1'b0;
    chk("wrap_drained", 64'(e), 64'd29);
    chk("wrap_end_valid", 64'(vld0), 64'd0);
    chk("wrap_end_state", 64'(st0), 64'd0);

    // asynchronous reset while in POST
    trig_val = 24'h000005;
    do_arm();
    for (int i = 1; i <= 6; i++) begin
      cap_en = 1'b1; ch_data = mk(i);
      tick();
    end
    cap_en = 1'b0;
    chk("post_state", 64'(st0), 64'd2);
    rst_n = 1'b0;
    #2;
    chk("rstpost_state", 64'(st0), 64'd0);
    chk("rstpost_count", 64'(cnt0), 64'd0);
    chk("rstpost_valid", 64'(vld0), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cap_en = 1'b1; ch_data = mk(i);
      tick();
    end
    cap_en = 1'b0;
    chk("rstpost_idle_count", 64'(cnt0), 64'd0);
    chk("rstpost_idle_state", 64'(st0), 64'd0);

    // out-of-range trigger channel never fires
    trig_val = 24'h123456;
    do_arm();
    for (int i = 0; i < 6; i++) begin
      trig_ch = (i < 3) ? 3'd6 : 3'd7;
      cap_en = 1'b1; ch_data = {CH{24'h123456}};
      tick();
    end
    cap_en = 1'b0;
    chk("oor_state", 64'(st0), 64'd1);
    chk("oor_count", 64'(cnt0), 64'd6);

    // POST_N=0 instance: trigger on first sample, ch3
    do_arm();
    trig_ch = 3'd3; trig_val = 24'hABCDEF;
    ch_data = mk(1); ch_data[3*W +: W] = 24'hABCDEF;
    cap_en = 1'b1;
    tick();
    cap_en = 1'b0;
    chk("p0_state", 64'(st1), 64'd3);
    chk("p0_count", 64'(cnt1), 64'd1);
    chk("p0_novalid", 64'(vld1), 64'd0);
    tick();
    chk("p0_valid", 64'(vld1), 64'd1);
    chk("p0_ch3", 64'(dat1[3*W +: W]), 64'h0ABCDEF);
    chk("p0_ch0", 64'(dat1[W-1:0]), 64'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("p0_end_valid", 64'(vld1), 64'd0);
    chk("p0_end_state", 64'(st1), 64'd0);
    chk("p0_end_count", 64'(cnt1), 64'd0);
    do_arm();
    cap_en = 1'b1;
    tick();
    cap_en = 1'b0;
    tick();
    chk("p0_again_valid", 64'(vld1), 64'd1);
    do_arm();
    chk("p0_rearm_state", 64'(st1), 64'd1);
    chk("p0_rearm_count", 64'(cnt1), 64'd0);
    chk("p0_rearm_valid", 64'(vld1), 64'd0);

    // timestamp spacing with cap_en every other cycle
    trig_ch = 3'd0; trig_val = 24'h000003;
    do_arm();
    for (int i = 1; i <= 8; i++) begin
      cap_en = 1'b1; ch_data = mk(i);
      tick();
      cap_en = 1'b0;
      tick();
    end
    chk("ts_count", 64'(cnt0), 64'd7);
    wait_valid0("ts_valid");
    rd_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      chk("ts_rd_ch0", 64'(dat0[W-1:0]), 64'(k));
`ifdef TRACE_TIMESTAMP_EN
      if (k > 1) chk("ts_step", 64'(ts0 - prev_ts), 64'd2);
`else
      chk("ts_zero", 64'(ts0), 64'd0);
`endif
      prev_ts = ts0;
      tick();
    end
    rd_ready = 1'b0;
    chk("ts_end_state", 64'(st0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buf.md
PIPE_TRACE_BUF -- requirements
Module: pipe_trace_buf

Interface
REQ-001 Parameter CHANNELS, default 6, number of pipeline stages traced per sample.
REQ-002 Parameter WIDTH, default 24, bits per channel.
REQ-003 Parameter DEPTH, default 16, trace entries; power of two, >=4.
REQ-004 Parameter POST_N, default 4, samples captured after trigger sample; 0 <= POST_N < DEPTH.
REQ-005 iw_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 iw_rst_n  in  1  asynchronous, active-low reset.
REQ-007 iw_arm  in  1  one-cycle pulse; clears buffer and starts capture.
REQ-008 iw_cap_en  in  1  sample strobe (pipeline advanced this cycle).
REQ-009 iw_ch_data  in  CHANNELS*WIDTH  concatenated stage values; channel 0 in LSBs.
REQ-010 iw_trig_ch  in  $clog2(CHANNELS)  channel compared for trigger.
REQ-011 iw_trig_val  in  WIDTH  trigger compare value.
REQ-012 ow_state  out  2  current FSM state encoding.
REQ-013 ow_count  out  $clog2(DEPTH)+1  valid entries held.
REQ-014 ow_rd_valid  out  1  readout entry available.
REQ-015 iw_rd_ready  in  1  consumer accepts entry when high with ow_rd_valid.
REQ-016 ow_rd_data  out  CHANNELS*WIDTH  readout sample.
REQ-017 ow_rd_ts  out  32  readout timestamp.

Function
REQ-018 FSM states: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-019 iw_arm in any state: next cycle ARMED, write pointer 0, ow_count 0, ow_rd_valid 0; iw_cap_en in the arm cycle writes nothing.
REQ-020 ARMED/POST: each iw_cap_en cycle writes iw_ch_data at write pointer, pointer increments modulo DEPTH; ow_count increments, saturating at DEPTH (oldest entry overwritten).
REQ-021 Trigger: ARMED, iw_cap_en high, and channel iw_trig_ch equals iw_trig_val; trigger sample is written; next state POST with post counter = POST_N, or DONE when POST_N=0.
REQ-022 POST: each written sample decrements post counter; the write that makes it 0 moves to DONE next cycle; triggers ignored.
REQ-023 IDLE and DONE: iw_cap_en ignored, buffer frozen.
REQ-024 DONE: entries read oldest first from (write pointer - ow_count) mod DEPTH; ow_rd_valid high 1 cycle after entering DONE if ow_count>0.
REQ-025 ow_rd_data/ow_rd_ts stable while ow_rd_valid high and iw_rd_ready low.
REQ-026 Handshake valid&ready pops one entry, ow_count decrements; sustained ready gives one entry per cycle (read prefetch).
REQ-027 Pop of the last entry: ow_rd_valid low next cycle, state IDLE.
REQ-028 Out-of-range iw_trig_ch never triggers.

Reset
REQ-029 Reset asserted: state IDLE, pointers 0, ow_count 0, ow_rd_valid 0, ow_rd_data 0, ow_rd_ts 0, timestamp counter 0, post counter 0; applies mid-capture or mid-readout.
REQ-030 Trace RAM contents not reset; unwritten entries never presented.

Configuration
REQ-031 Macro TRACE_TIMESTAMP_EN defined: free-running 32-bit cycle counter, wraps at 2^32, stored with every entry and returned on ow_rd_ts.
REQ-032 Macro undefined: no counter or timestamp storage; ow_rd_ts tied to 0.

Structure
REQ-033 Shared package trace_pkg holds state enum, state encodings, and timestamp width constant (32).
REQ-034 One sub-module trace_ram: single-clock simple dual-port RAM, DEPTH x (CHANNELS*WIDTH [+32]), registered read, no reset.

Verification (CHANNELS=6, WIDTH=24, DEPTH=16, POST_N=4)
REQ-035 Arm; 20 cap_en samples ch0=0x000001..0x000014; trigger ch0=0x00000A -> DONE after sample 0x0E, ow_count=14, readout ch0 0x01..0x0E in order, then IDLE.
REQ-036 Wrap: same stream, trigger 0x000018, 28 samples -> ow_count=16, readout ch0 0x0D..0x1C.
REQ-037 Backpressure: iw_rd_ready toggles 1,0,0,1 -> each entry held stable while not ready, no loss or duplication.
REQ-038 Reset pulse in POST -> next edge ow_state=0, ow_count=0, ow_rd_valid=0; further cap_en writes nothing.
REQ-039 POST_N=0, trigger ch3=0xABCDEF on first sample -> DONE, ow_count=1, single entry read; arm during DONE readout -> ARMED, count 0.
REQ-040 TRACE_TIMESTAMP_EN defined, cap_en every other cycle -> consecutive ow_rd_ts differ by 2; undefined -> ow_rd_ts=0.
